dvp_camera_transmitter: RTL and testbench

DVP_CAMERA_TRANSMITTER -- requirements
Module: dvp_camera_transmitter

---
 rtl/dvp_camera_transmitter.sv | 170 +++++++++++++++++
 tb/tb_dvp_camera_transmitter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dvp_camera_transmitter.sv
// DVP camera transmitter: streams RGB565 pixels as a byte-wide
// DVP raster with pclk, hsync and vsync derived from one clock.
module dvp_camera_transmitter #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 180,
  parameter int H_BLANK   = 16,
  parameter int V_BLANK   = 4,
  parameter int PCLK_HALF = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [15:0] pixel_data_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output logic        cam_pclk_out,
  output logic        cam_hsync_out,
  output logic        cam_vsync_out,
  output logic [7:0]  cam_data_out,
  output logic        frame_start_out,
  output logic        busy_out,
  output logic        underrun_out
);

  localparam int P2    = 2 * PCLK_HALF;
  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int LINES = V_ACTIVE + V_BLANK;
  localparam int PW    = (P2 > 2) ? $clog2(P2) : 1;
  localparam int POSW  = $clog2(LINE + 1);
  localparam int LNW   = $clog2(LINES + 1);

  localparam logic [PW-1:0]   PH_LAST  = PW'(P2 - 1);
  localparam logic [PW-1:0]   PH_HALF  = PW'(PCLK_HALF);
  localparam logic [POSW-1:0] ACT_LAST = POSW'(2 * H_ACTIVE - 1);
  localparam logic [POSW-1:0] POS_LAST = POSW'(LINE - 1);
  localparam logic [LNW-1:0]  LN_ALAST = LNW'(V_ACTIVE - 1);
  localparam logic [LNW-1:0]  LN_LAST  = LNW'(LINES - 1);

  typedef enum logic [1:0] {
    IDLE, ACTIVE, HBLANK, VBLANK
  } state_e;

  state_e          st_q, st_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [POSW-1:0] pos_q, pos_d;
  logic [LNW-1:0]  line_q, line_d;
  logic [15:0]     hold_q, hold_d;
  logic            full_q, full_d;
  logic [7:0]      lo_q, lo_d;
  logic [7:0]      data_q, data_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            fs_q, fs_d;
  logic            und_q, und_d;
  logic            tick, even, consume, ready, load;

  always_comb begin
    st_d   = st_q;
    pos_d  = pos_q;
    line_d = line_q;
    tick   = (ph_q == '0);
    ph_d   = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    if (tick) begin
      unique case (st_q)
        IDLE: begin
          if (enable_in) begin
            st_d   = ACTIVE;
            pos_d  = '0;
            line_d = '0;
          end
        end
        ACTIVE: begin
          pos_d = pos_q + 1'b1;
          if (pos_q == ACT_LAST) st_d = HBLANK;
        end
        HBLANK: begin
          pos_d = pos_q + 1'b1;
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            line_d = line_q + 1'b1;
            st_d   = (line_q == LN_ALAST) ? VBLANK : ACTIVE;
          end
        end
        VBLANK: begin
          pos_d = pos_q + 1'b1;
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            line_d = line_q + 1'b1;
            if (line_q == LN_LAST) begin
              line_d = '0;
              st_d   = enable_in ? ACTIVE : IDLE;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  // Even byte slot pops the holding register; odd byte replays its low half
  always_comb begin
    even    = tick && (st_d == ACTIVE) && !pos_d[0];
    consume = even && full_q;
    ready   = rst_n_in && (!full_q || consume);
    load    = pixel_valid_in && ready;
    full_d  = load || (full_q && !consume);
    hold_d  = load ? pixel_data_in : hold_q;
    lo_d    = lo_q;
    data_d  = data_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    fs_d    = 1'b0;
    und_d   = und_q;
    if (tick) begin
      hsync_d = (st_d == ACTIVE);
      vsync_d = (st_d == ACTIVE) || (st_d == HBLANK);
      fs_d    = (st_d == ACTIVE) &&
                ((st_q == IDLE) || (st_q == VBLANK));
      data_d  = '0;
      if (fs_d) und_d = 1'b0;
      if (even) begin
        data_d = full_q ? hold_q[15:8] : 8'h00;
        lo_d   = full_q ? hold_q[7:0] : 8'h00;
        if (!full_q) und_d = 1'b1;
      end else if (st_d == ACTIVE) begin
        data_d = lo_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      st_q    <= IDLE;
      ph_q    <= '0;
      pos_q   <= '0;
      line_q  <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      lo_q    <= '0;
      data_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      fs_q    <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      ph_q    <= ph_d;
      pos_q   <= pos_d;
      line_q  <= line_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      und_q   <= und_d;
    end
  end

  assign pixel_ready_out = ready;
  assign cam_pclk_out    = (ph_q >= PH_HALF);
  assign cam_hsync_out   = hsync_q;
  assign cam_vsync_out   = vsync_q;
  assign cam_data_out    = data_q;
  assign frame_start_out = fs_q;
  assign busy_out        = (st_q != IDLE);
  assign underrun_out    = und_q;

endmodule

// File: tb/tb_dvp_camera_transmitter.sv
// Randomized bench for dvp_camera_transmitter against a
// frame-slot arithmetic reference model.
module tb_dvp_camera_transmitter;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int HB = 2;
  localparam int VB = 1;
  localparam int PH = 2;
  localparam int P2 = 2 * PH;
  localparam int L  = 2 * HA + HB;
  localparam int FS = (VA + VB) * L;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_in = 1'b0;
  logic [15:0] pixel_data_in = '0;
  logic        pixel_valid_in = 1'b0;
  logic        pixel_ready_out;
  logic        cam_pclk_out;
  logic        cam_hsync_out;
  logic        cam_vsync_out;
  logic [7:0]  cam_data_out;
  logic        frame_start_out;
  logic        busy_out;
  logic        underrun_out;

  dvp_camera_transmitter #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .V_BLANK(VB), .PCLK_HALF(PH)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .enable_in(enable_in),
    .pixel_data_in(pixel_data_in),
    .pixel_valid_in(pixel_valid_in),
    .pixel_ready_out(pixel_ready_out),
    .cam_pclk_out(cam_pclk_out),
    .cam_hsync_out(cam_hsync_out),
    .cam_vsync_out(cam_vsync_out),
    .cam_data_out(cam_data_out),
    .frame_start_out(frame_start_out),
    .busy_out(busy_out),
    .underrun_out(underrun_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference model: position in the frame is a flat slot index
  int          cyc = 0;
  bit          run = 0;
  int          slot = 0;
  logic [15:0] q[$];
  logic [7:0]  lo = 0;
  bit          loaded = 0;
  logic        e_fs = 0, e_hs = 0, e_vs = 0;
  logic        e_und = 0, e_busy = 0, e_pclk = 0;
  logic [7:0]  e_data = 0;

  function automatic void advance(input bit en, output bit nr,
                                  output int ns, output bit tk);
    tk = (cyc % P2) == 0;
    nr = run;
    ns = slot;
    if (tk) begin
      if (!run) begin
        if (en) begin nr = 1; ns = 0; end
      end else begin
        ns = slot + 1;
        if (ns == FS) begin ns = 0; nr = en; end
      end
    end
  endfunction

  function automatic bit is_act(input bit nr, input int ns);
    return nr && (ns / L) < VA && (ns % L) < 2 * HA;
  endfunction

  function automatic bit consumes(input bit en);
    bit nr, tk;
    int ns;
    advance(en, nr, ns, tk);
    return tk && is_act(nr, ns) && ((ns % L) % 2 == 0)
           && q.size() > 0;
  endfunction

  always @(posedge clk) begin
    bit nr, tk, act, ev, ld;
    int ns;
    if (!rst_n) begin
      cyc = 0; run = 0; slot = 0; q.delete(); lo = 0;
      loaded = 0; e_fs = 0; e_hs = 0; e_vs = 0;
      e_und = 0; e_busy = 0; e_pclk = 0; e_data = 0;
    end else begin
      advance(enable_in, nr, ns, tk);
      act = is_act(nr, ns);
      ev  = tk && act && ((ns % L) % 2 == 0);
      ld  = pixel_valid_in &&
            (q.size() == 0 || (ev && q.size() > 0));
      e_fs = 0;
      if (tk) begin
        e_fs = nr && ns == 0;
        e_hs = act;
        e_vs = nr && (ns / L) < VA;
        if (e_fs) e_und = 0;
        e_data = 8'h00;
        if (ev) begin
          if (q.size() > 0) begin
            e_data = q[0][15:8];
            lo = q[0][7:0];
            void'(q.pop_front());
          end else begin
            lo = 8'h00;
            e_und = 1;
          end
        end else if (act) begin
          e_data = lo;
        end
      end
      if (ld) q.push_back(pixel_data_in);
      loaded = ld;
      run = nr;
      slot = ns;
      cyc = cyc + 1;
      e_busy = run;
      e_pclk = (cyc % P2) >= PH;
    end
  end

  int pix_idx = 0;

  task automatic run_cycles(input int n, input bit rst,
                            input bit en, input int pct);
    logic e_rdy;
    repeat (n) begin
      @(negedge clk);
      chk("outs",
          {18'd0, busy_out, underrun_out, frame_start_out,
           cam_hsync_out, cam_vsync_out, cam_pclk_out,
           cam_data_out},
          {18'd0, e_busy, e_und, e_fs, e_hs, e_vs, e_pclk,
           e_data});
      if (loaded) pix_idx++;
      rst_n = rst;
      enable_in = en;
      pixel_valid_in = ($urandom_range(0, 99) < pct);
      pixel_data_in = 16'h1234 + 16'(pix_idx) * 16'h4444;
      #1;
      e_rdy = rst_n && (q.size() == 0 || consumes(enable_in));
      chk("ready", {31'd0, pixel_ready_out}, {31'd0, e_rdy});
    end
  endtask

  initial begin
    run_cycles(5, 0, 0, 100);
    run_cycles(3, 1, 0, 100);
    run_cycles(260, 1, 1, 100);
    run_cycles(360, 1, 1, 70);
    run_cycles(200, 1, 1, 40);
    run_cycles(20, 1, 1, 100);
    run_cycles(150, 1, 0, 100);
    run_cycles(60, 1, 0, 60);
    run_cycles(3, 1, 0, 100);
    run_cycles(45, 1, 1, 100);
    run_cycles(2, 0, 1, 100);
    run_cycles(3, 1, 0, 100);
    run_cycles(400, 1, 1, 100);
    @(negedge clk);
    chk("no_underrun", {31'd0, underrun_out}, 32'd0);
    chk("busy_end", {31'd0, busy_out}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
